// File: rtl/cobs_encode.sv
// Purpose: COBS frame encoder. Buffers one block of non-zero bytes so that its
//          code byte goes out first, then the block data, then an optional 0x00.
// Latency: the code byte is presented the cycle after the block-closing byte is accepted.
// Backpressure: input stalls (o_ready=0) during emission; outputs hold while o_valid & !i_ready.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   i_data/i_valid/i_last    raw frame bytes in; o_ready accepts them
//   o_data/o_valid/o_last    encoded bytes out; i_ready accepts them
//                            o_last marks the final encoded byte of each frame
module cobs_encode #(
  parameter int MAX_BLOCK    = 254,
  parameter bit APPEND_DELIM = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  input  logic       i_last,
  output logic       o_ready,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_last
);

  localparam int AW = (MAX_BLOCK > 1) ? $clog2(MAX_BLOCK) : 1;
  localparam logic [7:0] FULL_CNT = 8'(MAX_BLOCK);

  typedef enum logic [2:0] {
    FILL  = 3'd0,
    CODE  = 3'd1,
    DATA  = 3'd2,
    TAIL  = 3'd3,
    DELIM = 3'd4
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] count_q, count_d;
  logic [7:0] rd_ptr_q, rd_ptr_d;
  logic       zero_term_q, zero_term_d;
  logic       frame_end_q, frame_end_d;

  logic [7:0] buffer_q [0:MAX_BLOCK-1];
  logic       wr_en;

  logic       last_rd;
  state_e     post_state;
  logic       frame_done_nodelim;

  assign last_rd = (rd_ptr_q == (count_q - 8'd1));

  // The frame finishes on this block's last CODE/DATA byte only when there is
  // neither a trailing empty block nor a delimiter still to send.
  assign frame_done_nodelim = !APPEND_DELIM && frame_end_q && !zero_term_q;

  // Where to go once the current block (code + data) has been fully sent.
  // A block closed by reaching MAX_BLOCK carries no implied zero, so only
  // zero_term forces the extra empty block at frame end.
  always_comb begin
    post_state = FILL;
    if (frame_end_q) begin
      if (zero_term_q) begin
        post_state = TAIL;
      end else if (APPEND_DELIM) begin
        post_state = DELIM;
      end else begin
        post_state = FILL;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    zero_term_d = zero_term_q;
    frame_end_d = frame_end_q;
    wr_en       = 1'b0;
    o_ready     = 1'b0;
    o_valid     = 1'b0;
    o_data      = 8'h00;
    o_last      = 1'b0;

    unique case (state_q)
      FILL: begin
        o_ready = 1'b1;
        if (i_valid) begin
          frame_end_d = i_last;
          rd_ptr_d    = 8'd0;
          if (i_data != 8'h00) begin
            wr_en   = 1'b1;
            count_d = count_q + 8'd1;
          end else begin
            zero_term_d = 1'b1;
          end
          if ((i_data == 8'h00) || i_last ||
              (count_q == FULL_CNT - 8'd1)) begin
            state_d = CODE;
          end
        end
      end

      CODE: begin
        o_valid = 1'b1;
        o_data  = count_q + 8'd1;
        o_last  = frame_done_nodelim && (count_q == 8'd0);
        if (i_ready) begin
          state_d = (count_q != 8'd0) ? DATA : post_state;
        end
      end

      DATA: begin
        o_valid = 1'b1;
        o_data  = buffer_q[rd_ptr_q[AW-1:0]];
        o_last  = frame_done_nodelim && last_rd;
        if (i_ready) begin
          if (last_rd) begin
            state_d = post_state;
          end else begin
            rd_ptr_d = rd_ptr_q + 8'd1;
          end
        end
      end

      TAIL: begin
        o_valid = 1'b1;
        o_data  = 8'h01;
        o_last  = !APPEND_DELIM;
        if (i_ready) begin
          state_d = APPEND_DELIM ? DELIM : FILL;
        end
      end

      DELIM: begin
        o_valid = 1'b1;
        o_data  = 8'h00;
        o_last  = 1'b1;
        if (i_ready) begin
          state_d = FILL;
        end
      end

      default: begin
        state_d = FILL;
      end
    endcase

    // Every return to FILL starts a fresh block.
    if ((state_q != FILL) && (state_d == FILL)) begin
      count_d     = 8'd0;
      rd_ptr_d    = 8'd0;
      zero_term_d = 1'b0;
      frame_end_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FILL;
      count_q     <= 8'd0;
      rd_ptr_q    <= 8'd0;
      zero_term_q <= 1'b0;
      frame_end_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      zero_term_q <= zero_term_d;
      frame_end_q <= frame_end_d;
    end
  end

  // Block storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      buffer_q[count_q[AW-1:0]] <= i_data;
    end
  end

endmodule

// File: doc/cobs_encode.md
Name: cobs_encode

Overview:
- Byte-stream COBS framer for the host reply path: uart TX <- cobs_encode <- response source.
- Reverse direction of the existing cobs_decode on the command path.
- Takes raw frame bytes with an end-of-frame flag and emits COBS-encoded bytes with no 0x00 inside the frame, then an optional 0x00 delimiter.
- Buffers one block (up to MAX_BLOCK non-zero bytes) so that the block's code byte is sent before the block's data bytes.

Parameters:
MAX_BLOCK, 254, maximum non-zero data bytes per block; code byte is at most MAX_BLOCK+1; legal range 1..254
APPEND_DELIM, 1, 1 = append 0x00 after each frame; 0 = no delimiter, o_last on the final code/data byte

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
i_data  input  8  raw frame byte
i_valid  input  1  i_data valid
i_last  input  1  i_data is the final byte of the frame
o_ready  output  1  encoder accepts input; transfer occurs when i_valid & o_ready
o_data  output  8  encoded byte
o_valid  output  1  o_data valid
i_ready  input  1  downstream accepts output; transfer occurs when o_valid & i_ready
o_last  output  1  final encoded byte of the frame

Behaviour:
- Reset (async assert, sync release): state FILL, count=0, o_valid=0, o_last=0, o_data=0x00, o_ready=1. Reset mid-frame discards the partial block and all pending output.
- Storage: MAX_BLOCK x 8 buffer, 8-bit count of stored bytes, read pointer, flags zero_term and frame_end.
- State FILL:
  - o_ready=1, o_valid=0.
  - On each accepted byte:
    - Non-zero byte: stored at buffer[count], count++.
    - 0x00 byte: not stored, zero_term=1, block closes.
  - Block also closes when count reaches MAX_BLOCK, or when the accepted byte has i_last=1 (frame_end=1).
  - On close, go to CODE on the next cycle.
- State CODE:
  - o_ready=0, o_valid=1, o_data=count+1.
  - On accept: go to DATA if count>0, otherwise to the post-block decision.
- State DATA:
  - o_data=buffer[rd_ptr], rd_ptr counts 0..count-1.
  - After the last data byte is accepted, go to the post-block decision.
- Post-block decision:
  - frame_end=0: clear count and flags, return to FILL.
  - frame_end=1 and zero_term=1: go to TAIL (a trailing zero needs an empty block).
  - frame_end=1 and zero_term=0: go to DELIM if APPEND_DELIM, else the frame is done.
  - A full block (code MAX_BLOCK+1) ending the frame gets no extra 0x01.
  - A full block followed by more data starts a new block; the full block carries no implied zero.
- State TAIL: o_data=0x01, then DELIM if APPEND_DELIM, else done.
- State DELIM: o_data=0x00, o_last=1, then FILL with count and flags cleared.
- o_last is high only with the frame's final output byte: the DELIM byte, or with APPEND_DELIM=0 the final CODE/DATA/TAIL byte.
- AXI-style output: while o_valid & !i_ready, o_data, o_valid and o_last stay stable. o_valid never drops without a transfer except on reset.
- Output is registered. The first byte (code) appears the cycle after the closing input byte is accepted. Back-to-back output at 1 byte/cycle while i_ready=1.
- Input is not accepted during emission (o_ready=0). Throughput: (block length + 1) + overhead cycles per block.
- Width: count fits 8 bits; code = count+1 ≤ 255, so no wrap.

Test Plan:
- Frame 11 22 00 33 (last on 33), i_ready=1 -> 03 11 22 02 33 00; o_last only on final 00.
- Single byte 00 with last -> 01 01 00.
- Frame 11 00 (last on 00) -> 02 11 01 00; with APPEND_DELIM=0 -> 02 11 01, o_last on 01.
- Frame 01..FE (254 non-zero bytes, last on FE) -> FF 01..FE 00, no 0x01 before the delimiter.
- Frame 01..FF (255 bytes) -> FF 01..FE 02 FF 00.
- Random i_ready (50%) and gappy i_valid on frame 11 22 00 33 -> identical byte sequence; o_data/o_last stable during stalls; o_ready=0 from block close until return to FILL.
- rst_n pulsed low while in DATA of a 200-byte block -> o_valid=0 immediately; after release o_ready=1; next frame AA last -> 02 AA 00.
